// File: rtl/pipe_pkg.sv
// Shared fetch-stage types and constants for ifid_stage_ctrl and fetch_pc_reg.
package pipe_pkg;
  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam int          RS1_LSB   = 15;
  localparam int          RS2_LSB   = 20;
  localparam int          REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  function automatic logic [REG_IDX_W-1:0] reg_field(input logic [31:0] inst, input int lsb);
    return inst[lsb +: REG_IDX_W];
  endfunction
endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC mux and a redirect latch that holds a branch target
// raised while the PC was stalled.
module fetch_pc_reg
  import pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] o_pc,
  output logic            o_redirect_pend
);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_saved_tgt;
  logic            r_pend;
  logic [XLEN-1:0] w_pc_nxt;

  // A fresh branch outranks an older latched redirect.
  always_comb begin
    w_pc_nxt = r_pc + STEP;
    if (branch_taken)   w_pc_nxt = branch_target;
    else if (r_pend)    w_pc_nxt = r_saved_tgt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_saved_tgt <= '0;
      r_pend      <= 1'b0;
    end else if (pc_write) begin
      r_pc   <= w_pc_nxt;
      r_pend <= 1'b0;
    end else if (branch_taken) begin
      r_saved_tgt <= branch_target;
      r_pend      <= 1'b1;
    end
  end

  assign o_pc            = r_pc;
  assign o_redirect_pend = r_pend;
endmodule

// File: rtl/ifid_stage_ctrl.sv
// Fetch stage: PC, IF/ID register and stall/flush/redirect handling.
// Define IFID_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
//
//   state    | meaning
//   ST_BOOT  | first cycle after reset; IF/ID captures but stays a bubble
//   ST_RUN   | pipeline advancing
//   ST_STALL | hazard unit holding PC and/or IF/ID
module ifid_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_write,
  input  logic                 ifid_write,
  input  logic                 ifid_flush,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_target,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [XLEN-1:0]      ifid_pc,
  output logic [31:0]          ifid_inst,
  output logic                 ifid_valid,
  output logic [REG_IDX_W-1:0] rs1_id,
  output logic [REG_IDX_W-1:0] rs2_id,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt,
`endif
  output logic                 redirect_pend
);
  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_inst;
  logic            r_ifid_valid;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .pc_write        (pc_write),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .o_pc            (w_pc),
    .o_redirect_pend (redirect_pend)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_BOOT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_RUN;
      ST_RUN:   if (!pc_write || !ifid_write) w_state_nxt = ST_STALL;
      ST_STALL: if (pc_write && ifid_write)   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  // Flush wins over capture and leaves the held PC untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifid_pc    <= '0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else if (ifid_flush) begin
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else if (ifid_write) begin
      r_ifid_pc    <= w_pc;
      r_ifid_inst  <= imem_rdata;
      r_ifid_valid <= (r_state != ST_BOOT);
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == ST_STALL && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (ifid_flush && r_flush_cnt != '1)          r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign imem_addr  = w_pc;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_inst  = r_ifid_inst;
  assign ifid_valid = r_ifid_valid;
  assign rs1_id     = reg_field(r_ifid_inst, RS1_LSB);
  assign rs2_id     = reg_field(r_ifid_inst, RS2_LSB);
endmodule
